// File: rtl/sp_rcv_if.sv
// ============================================================================
// Module      : sp_rcv_if
// Description : Receive-word, host-buffer and trigger bundle for sp_rcv_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sp_rcv_if;
    logic [15:0] rcv_data;
    logic        rcv_strobe;
    logic        buf_space_ok;
    logic        trigger;
    logic        buf_wreq;
    logic [15:0] buf_wdata;
    logic        frame_done;
    logic        frame_abort;
    logic        sync_ok;

    modport master (
        input  rcv_data, rcv_strobe, buf_space_ok,
        output trigger, buf_wreq, buf_wdata, frame_done, frame_abort, sync_ok
    );

    modport slave (
        output rcv_data, rcv_strobe, buf_space_ok,
        input  trigger, buf_wreq, buf_wdata, frame_done, frame_abort, sync_ok
    );
endinterface

`default_nettype wire

// File: rtl/sp_rcv_ctrl.sv
// ============================================================================
// Module      : sp_rcv_ctrl
// Description : Spectrum receive controller: triggers Mercury, frames words
//               into the host buffer, watchdog-driven resynchronisation.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sp_rcv_ctrl #(
    parameter int FRAME_LEN     = 4096,
    parameter int GUARD         = 64,
    parameter int TIMEOUT       = 1048576,
    parameter int RESYNC_CYCLES = 262144
) (
    input  wire logic    clk,
    input  wire logic    rst,
    sp_rcv_if.master     bus
);

    localparam int c_cnt_max = (RESYNC_CYCLES > GUARD) ? RESYNC_CYCLES : GUARD;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_wd_w    = $clog2(TIMEOUT + 1);
    localparam int c_wc_w    = $clog2(FRAME_LEN + 1);

    localparam logic [c_cnt_w-1:0] c_resync_last = c_cnt_w'(RESYNC_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_guard_last  = c_cnt_w'(GUARD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_wd_w-1:0]  c_wd_last     = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_wd_w-1:0]  c_wd_one      = c_wd_w'(1);
    localparam logic [c_wc_w-1:0]  c_frame_len   = c_wc_w'(FRAME_LEN);
    localparam logic [c_wc_w-1:0]  c_wc_one      = c_wc_w'(1);

    localparam logic [2:0] c_st_resync     = 3'd0;
    localparam logic [2:0] c_st_arm        = 3'd1;
    localparam logic [2:0] c_st_guard      = 3'd2;
    localparam logic [2:0] c_st_wait_first = 3'd3;
    localparam logic [2:0] c_st_recv       = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_wd_w-1:0]  r_wd;
    logic [c_wc_w-1:0]  r_words;
    logic [c_wc_w-1:0]  w_words_inc;

    logic w_watch;
    logic w_accept;
    logic w_last;
    logic w_expire;
    logic w_state_chg;

    logic w_trigger, w_wreq, w_done, w_abort, w_sync;
    logic r_trigger, r_wreq, r_done, r_abort, r_sync;
    logic [15:0] r_wdata;

    assign w_watch     = (r_state == c_st_guard) || (r_state == c_st_wait_first) ||
                         (r_state == c_st_recv);
    assign w_accept    = bus.rcv_strobe &&
                         ((r_state == c_st_wait_first) || (r_state == c_st_recv));
    assign w_words_inc = (r_state == c_st_wait_first) ? c_wc_one : (r_words + c_wc_one);
    assign w_last      = (w_words_inc == c_frame_len);
    // A strobe on the expiry cycle wins over the watchdog.
    assign w_expire    = w_watch && !bus.rcv_strobe && (r_wd == c_wd_last);
    assign w_state_chg = (w_next_state != r_state);

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_resync;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_state_chg)
                r_cnt <= '0;
            else if ((r_state == c_st_resync) || (r_state == c_st_guard))
                r_cnt <= r_cnt + c_cnt_one;

            if (!w_watch || bus.rcv_strobe || w_state_chg)
                r_wd <= '0;
            else
                r_wd <= r_wd + c_wd_one;

            if (w_accept && !w_last)
                r_words <= w_words_inc;
            else if (w_accept || w_state_chg)
                r_words <= '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_resync: begin
                if (r_cnt == c_resync_last)
                    w_next_state = c_st_arm;
            end
            c_st_arm: begin
                if (bus.buf_space_ok)
                    w_next_state = c_st_guard;
            end
            c_st_guard: begin
                if (w_expire)
                    w_next_state = c_st_resync;
                else if (r_cnt == c_guard_last)
                    w_next_state = c_st_wait_first;
            end
            c_st_wait_first: begin
                if (w_accept)
                    w_next_state = w_last ? c_st_arm : c_st_recv;
                else if (w_expire)
                    w_next_state = c_st_resync;
            end
            c_st_recv: begin
                if (w_accept && w_last)
                    w_next_state = c_st_arm;
                else if (w_expire)
                    w_next_state = c_st_resync;
            end
            default: w_next_state = c_st_resync;
        endcase
    end

    // Trigger follows the state being entered so it drops on the first-word edge.
    always_comb begin
        w_trigger = (w_next_state == c_st_guard) || (w_next_state == c_st_wait_first);
        w_wreq    = w_accept;
        w_done    = w_accept && w_last;
        w_abort   = w_expire;
        w_sync    = r_sync;
        if (w_done)
            w_sync = 1'b1;
        else if (w_expire)
            w_sync = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trigger <= 1'b0;
            r_wreq    <= 1'b0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            r_sync    <= 1'b0;
        end else begin
            r_trigger <= w_trigger;
            r_wreq    <= w_wreq;
            r_done    <= w_done;
            r_abort   <= w_abort;
            r_sync    <= w_sync;
            if (w_accept)
                r_wdata <= bus.rcv_data;
        end
    end

    assign bus.trigger     = r_trigger;
    assign bus.buf_wreq    = r_wreq;
    assign bus.buf_wdata   = r_wdata;
    assign bus.frame_done  = r_done;
    assign bus.frame_abort = r_abort;
    assign bus.sync_ok     = r_sync;

endmodule

`default_nettype wire

// File: tb/tb_sp_rcv_ctrl.sv
// ============================================================================
// Module      : tb_sp_rcv_ctrl
// Description : Self-checking bench for sp_rcv_ctrl against a timestamp model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sp_rcv_ctrl;

    localparam int FL = 8;
    localparam int GD = 4;
    localparam int TO = 100;
    localparam int RS = 50;

    localparam int P_RESYNC = 0;
    localparam int P_ARM    = 1;
    localparam int P_GUARD  = 2;
    localparam int P_WAIT   = 3;
    localparam int P_RECV   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sp_rcv_if bus();

    sp_rcv_ctrl #(
        .FRAME_LEN     (FL),
        .GUARD         (GD),
        .TIMEOUT       (TO),
        .RESYNC_CYCLES (RS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase plus absolute timestamps of phase entry / last activity.
    int          m_phase = P_RESYNC;
    int          m_cyc   = 0;
    int          m_start = 0;
    int          m_last  = 0;
    int          m_words = 0;
    int          m_frames = 0;
    bit          e_trig, e_wreq, e_done, e_abort, e_sync;
    logic [15:0] e_wdata;

    int n_done_seen  = 0;
    int n_abort_seen = 0;
    int n_wreq_seen  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic m_enter(input int p);
        m_phase = p;
        m_start = m_cyc;
        m_last  = m_cyc;
    endtask

    task automatic m_abort();
        e_abort = 1'b1;
        e_sync  = 1'b0;
        m_words = 0;
        m_enter(P_RESYNC);
    endtask

    task automatic model_edge();
        bit          s  = bus.rcv_strobe;
        logic [15:0] d  = bus.rcv_data;
        bit          sp = bus.buf_space_ok;
        bit          due;
        m_cyc++;
        e_wreq  = 1'b0;
        e_done  = 1'b0;
        e_abort = 1'b0;
        if (rst) begin
            m_words = 0;
            e_trig  = 1'b0;
            e_wdata = '0;
            e_sync  = 1'b0;
            m_enter(P_RESYNC);
            return;
        end
        if (s)
            m_last = m_cyc;
        due = !s && ((m_cyc - m_last) == TO);
        case (m_phase)
            P_RESYNC: if ((m_cyc - m_start) == RS) m_enter(P_ARM);
            P_ARM:    if (sp) m_enter(P_GUARD);
            P_GUARD: begin
                if (due) m_abort();
                else if ((m_cyc - m_start) == GD) m_enter(P_WAIT);
            end
            default: begin
                if (s) begin
                    e_wreq  = 1'b1;
                    e_wdata = d;
                    m_words = (m_phase == P_WAIT) ? 1 : m_words + 1;
                    if (m_words == FL) begin
                        e_done  = 1'b1;
                        e_sync  = 1'b1;
                        m_words = 0;
                        m_frames++;
                        m_enter(P_ARM);
                    end else if (m_phase == P_WAIT) begin
                        m_enter(P_RECV);
                    end
                end else if (due) begin
                    m_abort();
                end
            end
        endcase
        e_trig = (m_phase == P_GUARD) || (m_phase == P_WAIT);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("trigger",     32'(bus.trigger),     32'(e_trig));
        check_eq("buf_wreq",    32'(bus.buf_wreq),    32'(e_wreq));
        check_eq("buf_wdata",   32'(bus.buf_wdata),   32'(e_wdata));
        check_eq("frame_done",  32'(bus.frame_done),  32'(e_done));
        check_eq("frame_abort", 32'(bus.frame_abort), 32'(e_abort));
        check_eq("sync_ok",     32'(bus.sync_ok),     32'(e_sync));
        if (bus.frame_done)  n_done_seen++;
        if (bus.frame_abort) n_abort_seen++;
        if (bus.buf_wreq)    n_wreq_seen++;
    endtask

    task automatic idle(input int n);
        bus.rcv_strobe = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [15:0] d);
        bus.rcv_strobe = 1'b1;
        bus.rcv_data   = d;
        step();
        bus.rcv_strobe = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int budget);
        int k = 0;
        while (m_phase != p && k < budget) begin
            step();
            k++;
        end
        check_eq("reach_phase", 32'(m_phase), 32'(p));
    endtask

    initial begin
        int base_w, base_d, trig_hi, quiet;
        rst = 1'b1;
        bus.rcv_strobe   = 1'b0;
        bus.rcv_data     = '0;
        bus.buf_space_ok = 1'b1;
        idle(2);
        check_eq("reset_outputs",
                 32'({bus.trigger, bus.buf_wreq, bus.buf_wdata, bus.frame_done,
                      bus.frame_abort, bus.sync_ok}), 32'd0);
        rst = 1'b0;

        // Resync window with filler words every third clock
        base_w  = n_wreq_seen;
        trig_hi = 0;
        for (int i = 0; i < RS; i++) begin
            bus.rcv_strobe = (i % 3 == 0);
            bus.rcv_data   = 16'($urandom);
            step();
            if (bus.trigger) trig_hi++;
        end
        bus.rcv_strobe = 1'b0;
        check_eq("resync_trig_low", 32'(trig_hi), 32'd0);
        check_eq("resync_no_write", 32'(n_wreq_seen - base_w), 32'd0);
        step();
        check_eq("trig_rise", 32'(bus.trigger), 32'd1);

        // Guard filler, then one full frame
        idle(1);
        base_w = n_wreq_seen;
        send(16'hAAAA);
        check_eq("guard_discard", 32'(n_wreq_seen - base_w), 32'd0);
        wait_phase(P_WAIT, 20);
        base_w = n_wreq_seen;
        base_d = n_done_seen;
        for (int k = 1; k <= FL; k++) begin
            if (k == FL) bus.buf_space_ok = 1'b0;
            send(16'(k));
            check_eq("frame_wreq", 32'(bus.buf_wreq), 32'd1);
            check_eq("frame_wdata", 32'(bus.buf_wdata), 32'(k));
            if (k == 1) check_eq("trig_fall", 32'(bus.trigger), 32'd0);
            if (k < FL) idle($urandom_range(0, 2));
        end
        check_eq("frame_done_last", 32'(bus.frame_done), 32'd1);
        check_eq("sync_after_frame", 32'(bus.sync_ok), 32'd1);
        check_eq("frame_write_count", 32'(n_wreq_seen - base_w), 32'(FL));
        check_eq("frame_done_count", 32'(n_done_seen - base_d), 32'd1);

        // ARM holds while host buffer is short of space
        base_w  = n_wreq_seen;
        trig_hi = 0;
        for (int i = 0; i < 200; i++) begin
            bus.rcv_strobe = ($urandom_range(0, 3) == 0);
            bus.rcv_data   = 16'($urandom);
            step();
            if (bus.trigger) trig_hi++;
        end
        bus.rcv_strobe = 1'b0;
        check_eq("arm_trig_low", 32'(trig_hi), 32'd0);
        check_eq("arm_no_write", 32'(n_wreq_seen - base_w), 32'd0);
        bus.buf_space_ok = 1'b1;
        step();
        check_eq("space_trig_rise", 32'(bus.trigger), 32'd1);

        // Stall after five words: watchdog abort
        wait_phase(P_WAIT, 20);
        base_d = n_done_seen;
        for (int k = 1; k <= 5; k++) send(16'(16'h0100 + k));
        idle(TO - 1);
        check_eq("abort_not_early", 32'(bus.frame_abort), 32'd0);
        step();
        check_eq("abort_at_timeout", 32'(bus.frame_abort), 32'd1);
        check_eq("sync_cleared", 32'(bus.sync_ok), 32'd0);
        trig_hi = 0;
        for (int i = 0; i < RS; i++) begin
            step();
            if (bus.trigger) trig_hi++;
        end
        check_eq("post_abort_trig_low", 32'(trig_hi), 32'd0);
        check_eq("abort_no_done", 32'(n_done_seen - base_d), 32'd0);

        // Strobe landing on the expiry cycle wins
        wait_phase(P_WAIT, 200);
        for (int k = 1; k <= 3; k++) send(16'(16'h0200 + k));
        idle(TO - 1);
        send(16'h0204);
        check_eq("expiry_strobe_wreq", 32'(bus.buf_wreq), 32'd1);
        check_eq("expiry_strobe_data", 32'(bus.buf_wdata), 32'h0204);
        check_eq("expiry_strobe_no_abort", 32'(bus.frame_abort), 32'd0);
        for (int k = 5; k <= FL; k++) send(16'(16'h0200 + k));
        check_eq("expiry_frame_done", 32'(bus.frame_done), 32'd1);

        // Reset mid-frame, then a clean restarted frame
        wait_phase(P_WAIT, 20);
        for (int k = 1; k <= 3; k++) send(16'(16'h0300 + k));
        base_d = n_done_seen;
        rst = 1'b1;
        step();
        check_eq("midframe_rst_outputs",
                 32'({bus.trigger, bus.buf_wreq, bus.buf_wdata, bus.frame_done,
                      bus.frame_abort, bus.sync_ok}), 32'd0);
        rst = 1'b0;
        wait_phase(P_WAIT, 200);
        base_w = n_wreq_seen;
        for (int k = 1; k <= FL; k++) send(16'(16'h0400 + k));
        check_eq("restart_writes", 32'(n_wreq_seen - base_w), 32'(FL));
        check_eq("restart_done", 32'(n_done_seen - base_d), 32'd1);

        // Randomised traffic, space toggling, quiet spells near the timeout, rare resets
        quiet = 0;
        for (int i = 0; i < 4000; i++) begin
            if (quiet > 0) begin
                quiet--;
                bus.rcv_strobe = 1'b0;
            end else begin
                bus.rcv_strobe = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 299) == 0) quiet = $urandom_range(95, 102);
            end
            bus.rcv_data = 16'($urandom);
            if ($urandom_range(0, 49) == 0) bus.buf_space_ok = ~bus.buf_space_ok;
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;
        check_eq("frames_total", 32'(n_done_seen), 32'(m_frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
